// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/sram_arb_fsm.sv
// Grant state machine: round-robin pointer, bounded lock bursts, registered grants.
module sram_arb_fsm
    import sram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic lock0,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1,
    output logic access0,
    output logic access1
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             burst_at_max;

    assign access0      = (state_q == OWN0) && req0;
    assign access1      = (state_q == OWN1) && req1;
    assign burst_at_max = (burst_cnt_q == BURST_LAST);
    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req0 && (!req1 || rr_ptr_q == PORT_CPU)) state_d = OWN0;
                else if (req1)                               state_d = OWN1;
            end
            OWN0: begin
                if (!req0)                                 state_d = req1 ? OWN1 : IDLE;
                else if (req1 && (!lock0 || burst_at_max)) state_d = OWN1;
            end
            OWN1: begin
                if (!req1)                                 state_d = req0 ? OWN0 : IDLE;
                else if (req0 && (!lock1 || burst_at_max)) state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase

        // Saturation lets an uncontested owner keep the grant indefinitely.
        if (state_d != state_q)                          burst_cnt_d = '0;
        else if ((access0 || access1) && !burst_at_max)  burst_cnt_d = burst_cnt_q + CNT_W'(1);

        if (state_d == OWN0)      rr_ptr_d = PORT_DMA;
        else if (state_d == OWN1) rr_ptr_d = PORT_CPU;

        gnt0_d = (state_d == OWN0);
        gnt1_d = (state_d == OWN1);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PORT_CPU;
            burst_cnt_q <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master front end for the single-port SRAM: grant FSM plus address/data mux
// and per-port registered read data.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic                 lock0,
    input  logic                 lock1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata0,
    input  logic [WORD_SIZE-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic [WORD_SIZE-1:0] rdata0,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    logic                 access0, access1;
    logic [WORD_SIZE-1:0] rdata0_q, rdata0_d;
    logic [WORD_SIZE-1:0] rdata1_q, rdata1_d;
    logic                 rvalid0_q, rvalid0_d;
    logic                 rvalid1_q, rvalid1_d;

    sram_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .lock0   (lock0),
        .lock1   (lock1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .access0 (access0),
        .access1 (access1)
    );

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
        // Reset gating keeps an in-flight burst write from landing in memory.
        mem_write = !rst && ((access0 && we0) || (access1 && we1));
    end

    always_comb begin
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        if (access0 && !we0) begin
            rdata0_d  = mem_rdata;
            rvalid0_d = 1'b1;
        end
        if (access1 && !we1) begin
            rdata1_d  = mem_rdata;
            rvalid1_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scenario bench for sram_arbiter with a behavioural SRAM and a read-data scoreboard.
module tb_sram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic       lock0 = 1'b0, lock1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1;
    logic [7:0] rdata0, rdata1;
    logic       rvalid0, rvalid1;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_write;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] mem [256];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    sram_arbiter #(
        .WORD_SIZE (8),
        .ADDR_SIZE (8),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    // Behavioural SRAM: combinational read, write at the clock edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] = mem_wdata;

    // Scoreboard: a read access pushes the word the SRAM holds; the next cycle pops it.
    always @(negedge clk) begin : monitor
        logic [7:0] exp_d;
        logic       exp_w;
        logic [7:0] exp_a, exp_wd;

        vectors++;
        if (rvalid0 !== (q0.size() != 0)) begin
            miscompares++;
            $display("FAIL sb_rvalid0: got %b expected %b", rvalid0, q0.size() != 0);
        end
        if (q0.size() != 0) begin
            exp_d = q0.pop_front();
            vectors++;
            if (rdata0 !== exp_d) begin
                miscompares++;
                $display("FAIL sb_rdata0: got %h expected %h", rdata0, exp_d);
            end
        end
        vectors++;
        if (rvalid1 !== (q1.size() != 0)) begin
            miscompares++;
            $display("FAIL sb_rvalid1: got %b expected %b", rvalid1, q1.size() != 0);
        end
        if (q1.size() != 0) begin
            exp_d = q1.pop_front();
            vectors++;
            if (rdata1 !== exp_d) begin
                miscompares++;
                $display("FAIL sb_rdata1: got %h expected %h", rdata1, exp_d);
            end
        end

        if (!rst && gnt0 && req0 && !we0) q0.push_back(mem[addr0]);
        if (!rst && gnt1 && req1 && !we1) q1.push_back(mem[addr1]);

        exp_w  = !rst && ((gnt0 && req0 && we0) || (gnt1 && req1 && we1));
        exp_a  = gnt0 ? addr0 : addr1;
        exp_wd = gnt0 ? wdata0 : wdata1;
        vectors++;
        if (mem_write !== exp_w) begin
            miscompares++;
            $display("FAIL sb_mem_write: got %b expected %b", mem_write, exp_w);
        end else if (exp_w) begin
            vectors++;
            if (mem_addr !== exp_a || mem_wdata !== exp_wd) begin
                miscompares++;
                $display("FAIL sb_mem_port: got %h/%h expected %h/%h",
                         mem_addr, mem_wdata, exp_a, exp_wd);
            end
        end
        vectors++;
        if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
            miscompares++;
            $display("FAIL sb_onehot: got gnt0=%b gnt1=%b expected at most one", gnt0, gnt1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req0 = 1'b0; req1 = 1'b0;
        we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        step();
        step();
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0;
        we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
        step();
        step();
        vectors++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gnt: got %b%b expected 00", gnt0, gnt1);
        end
        vectors++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rd: got rv=%b%b rd=%h/%h expected 00 00/00",
                     rvalid0, rvalid1, rdata0, rdata1);
        end
        vectors++;
        if (mem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mem_write: got %b expected 0", mem_write);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_gnt: got %b%b expected 10", gnt0, gnt1);
        end
        idle_all();
    endtask

    task automatic test_single_read();
        do_reset();
        mem[8'h10] = 8'hA5;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        step();
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL read_gnt0: got %b expected 1", gnt0);
        end
        step();
        vectors++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5) begin
            miscompares++;
            $display("FAIL read_data0: got rv=%b rd=%h expected rv=1 rd=a5", rvalid0, rdata0);
        end
        idle_all();
    endtask

    task automatic test_rr_pointer();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h11;
        step();
        step();
        req0 = 1'b0;
        step();
        vectors++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_idle: got %b%b expected 00", gnt0, gnt1);
        end
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h12;
        step();
        vectors++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_tie_after_port0: got %b%b expected 01", gnt0, gnt1);
        end
        idle_all();
    endtask

    task automatic test_round_robin();
        logic exp_g0;
        do_reset();
        mem[8'h31] = 8'h77;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h5A;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h31;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_g0 = (k <= 8) && (k % 2 == 1);
            vectors++;
            if (gnt0 !== exp_g0 || gnt1 !== !exp_g0) begin
                miscompares++;
                $display("FAIL rr_alternate step %0d: got %b%b expected %b%b",
                         k, gnt0, gnt1, exp_g0, !exp_g0);
            end
            if (k == 8) req0 = 1'b0;
        end
        idle_all();
        vectors++;
        if (mem[8'h30] !== 8'h5A) begin
            miscompares++;
            $display("FAIL rr_write_landed: got %h expected 5a", mem[8'h30]);
        end
    endtask

    task automatic test_locked_burst();
        logic exp_g1 [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic acc1;
        int   idx = 0;
        do_reset();
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 8'h20; wdata1 = 8'hC0;
        for (int k = 0; k < 10; k++) begin
            acc1 = gnt1 && req1;
            step();
            vectors++;
            if (gnt1 !== exp_g1[k] || gnt0 !== !exp_g1[k]) begin
                miscompares++;
                $display("FAIL burst_gnt step %0d: got %b%b expected %b%b",
                         k, gnt0, gnt1, !exp_g1[k], exp_g1[k]);
            end
            if (k == 0) begin
                req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
            end
            if (acc1) idx++;
            if (idx >= 8) req1 = 1'b0;
            else begin
                addr1  = 8'h20 + 8'(idx);
                wdata1 = 8'hC0 + 8'(idx);
            end
        end
        idle_all();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (mem[8'h20 + 8'(i)] !== 8'hC0 + 8'(i)) begin
                miscompares++;
                $display("FAIL burst_mem[%0d]: got %h expected %h",
                         i, mem[8'h20 + 8'(i)], 8'hC0 + 8'(i));
            end
        end
    endtask

    task automatic test_uncontested_lock();
        logic acc0;
        int   idx = 0;
        do_reset();
        for (int i = 0; i < 10; i++) mem[8'h50 + 8'(i)] = 8'h60 + 8'(i);
        req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 8'h50;
        for (int k = 0; k <= 10; k++) begin
            acc0 = gnt0 && req0;
            step();
            vectors++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                miscompares++;
                $display("FAIL lock_hold step %0d: got %b%b expected 10", k, gnt0, gnt1);
            end
            if (acc0) begin
                vectors++;
                if (rvalid0 !== 1'b1 || rdata0 !== 8'h60 + 8'(idx)) begin
                    miscompares++;
                    $display("FAIL lock_read %0d: got rv=%b rd=%h expected rv=1 rd=%h",
                             idx, rvalid0, rdata0, 8'h60 + 8'(idx));
                end
                idx++;
            end
            if (idx >= 10) req0 = 1'b0;
            else           addr0 = 8'h50 + 8'(idx);
        end
        vectors++;
        if (idx != 10) begin
            miscompares++;
            $display("FAIL lock_count: got %0d expected 10", idx);
        end
        idle_all();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        mem[8'h70] = 8'h11;
        mem[8'h71] = 8'h22;
        req0 = 1'b1; we0 = 1'b1; lock0 = 1'b1; addr0 = 8'h70; wdata0 = 8'hEE;
        step();
        step();
        addr0 = 8'h71; wdata0 = 8'hEF;
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_mem_write: got %b expected 0", mem_write);
        end
        step();
        vectors++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: got gnt=%b%b rv0=%b expected 00 0", gnt0, gnt1, rvalid0);
        end
        vectors++;
        if (mem[8'h70] !== 8'hEE || mem[8'h71] !== 8'h22) begin
            miscompares++;
            $display("FAIL midrst_mem: got %h/%h expected ee/22", mem[8'h70], mem[8'h71]);
        end
        rst = 1'b0;
        lock0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h72;
        step();
        vectors++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_rr_ptr: got %b%b expected 10", gnt0, gnt1);
        end
        idle_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        test_reset();
        test_single_read();
        test_rr_pointer();
        test_round_robin();
        test_locked_burst();
        test_uncontested_lock();
        test_reset_mid_burst();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
